// File: rtl/stochastic_to_binary_decoder.sv
// Stochastic-to-binary decoder: counts '1' bits of a unipolar stochastic
// bitstream over a window of WINDOW accepted samples and publishes the count.
module stochastic_to_binary_decoder #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             sbs_in_i,
    input  logic             sbs_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] value_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(WINDOW - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ones_q, ones_d;
    logic [WIDTH-1:0]   samp_q, samp_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               done_q, done_d;
    logic               accept;

    assign accept = sbs_valid_i && !abort_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ones_q  <= '0;
            samp_q  <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            samp_q  <= samp_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        samp_d  = samp_q;
        value_d = value_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACC;
                    ones_d  = '0;
                    samp_d  = '0;
                end
            end
            ACC: begin
                // abort outranks both a normal accept and the window-closing one
                if (abort_i) begin
                    state_d = IDLE;
                    ones_d  = '0;
                    samp_d  = '0;
                end else if (accept) begin
                    if (samp_q == LAST_IDX) begin
                        value_d = ones_q + WIDTH'(sbs_in_i);
                        done_d  = 1'b1;
                        ones_d  = '0;
                        samp_d  = '0;
                        state_d = cont_i ? ACC : IDLE;
                    end else begin
                        samp_d = samp_q + WIDTH'(1);
                        ones_d = ones_q + WIDTH'(sbs_in_i);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q == ACC);
    assign done_o  = done_q;
    assign value_o = value_q;

endmodule
